// File: rtl/tlb_inv_sweeper.sv
// -----------------------------------------------------------------------------
// tlb_inv_sweeper
//
// Executes a LoongArch INVTLB by reading every TLB entry in turn through the
// TLB read port and issuing a "clear E" write for each entry that matches the
// requested op. The TLB write port is shared with the WB-stage TLBWR/TLBFILL
// path; a WB write always takes the port, and the sweep stalls on that index
// so the entry is re-evaluated on the following cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   op_valid/op_ready   INVTLB request handshake from WB (ready only in IDLE)
//   op_code/op_asid/op_vppn  INVTLB operands
//   busy, done, op_err  sweep status; done pulses one cycle, op_err qualifies it
//   r_index, r_*        TLB read port (read data is combinational)
//   wb_we, wb_index     WB write request
//   we, w_index, w_inv  merged TLB write port (w_inv=1: clear E only)
//   inv_count           (TLB_INV_COUNT_EN only) entries invalidated by last op
//
// Configuration macro: TLB_INV_COUNT_EN adds the inv_count output.
// -----------------------------------------------------------------------------
module tlb_inv_sweeper #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [4:0]      op_code,
    input  logic [9:0]      op_asid,
    input  logic [18:0]     op_vppn,
    output logic            busy,
    output logic            done,
    output logic            op_err,
    output logic [IDXW-1:0] r_index,
    input  logic            r_e,
    input  logic [18:0]     r_vppn,
    input  logic [5:0]      r_ps,
    input  logic [9:0]      r_asid,
    input  logic            r_g,
    input  logic            wb_we,
    input  logic [IDXW-1:0] wb_index,
    output logic            we,
    output logic [IDXW-1:0] w_index,
    output logic            w_inv
`ifdef TLB_INV_COUNT_EN
    ,
    output logic [IDXW:0]   inv_count
`endif
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q,   idx_d;
    logic [4:0]      code_q,  code_d;
    logic [9:0]      asid_q,  asid_d;
    logic [18:0]     vppn_q,  vppn_d;
    logic            err_q,   err_d;

    logic asid_match;
    logic va_match;
    logic hit;
    logic inv_we;

    // Entry match against the latched operands, evaluated on this cycle's read data.
    always_comb begin
        asid_match = (r_asid == asid_q);
        // A 2 MB page ignores the low VPPN bits that fall inside the page.
        if (r_ps == 6'd21) begin
            va_match = (r_vppn[18:9] == vppn_q[18:9]);
        end else begin
            va_match = (r_vppn == vppn_q);
        end
        hit = 1'b0;
        case (code_q)
            5'd0, 5'd1: hit = 1'b1;
            5'd2:       hit = r_g;
            5'd3:       hit = ~r_g;
            5'd4:       hit = ~r_g & asid_match;
            5'd5:       hit = ~r_g & asid_match & va_match;
            5'd6:       hit = (r_g | asid_match) & va_match;
            default:    hit = 1'b0;
        endcase
    end

    // A WB write owns the port this cycle, so no invalidate is issued.
    assign inv_we = (state_q == ST_SWEEP) & r_e & hit & ~wb_we;

    // Next-state and outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        code_d   = code_q;
        asid_d   = asid_q;
        vppn_d   = vppn_q;
        err_d    = err_q;

        op_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        op_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (op_code <= 5'd6) begin
                        state_d = ST_SWEEP;
                        idx_d   = '0;
                        code_d  = op_code;
                        asid_d  = op_asid;
                        vppn_d  = op_vppn;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_SWEEP: begin
                busy = 1'b1;
                // Stalled cycles hold idx so the same entry is looked at again.
                if (!wb_we) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                op_err  = err_q;
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    // idx is kept at zero outside a sweep, so the read index needs no mux.
    assign r_index = idx_q;
    assign we      = wb_we | inv_we;
    assign w_index = wb_we ? wb_index : idx_q;
    assign w_inv   = inv_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            code_q  <= '0;
            asid_q  <= '0;
            vppn_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            asid_q  <= asid_d;
            vppn_q  <= vppn_d;
            err_q   <= err_d;
        end
    end

`ifdef TLB_INV_COUNT_EN
    logic [IDXW:0] cnt_q, cnt_d;

    // Cleared on any accept (legal or not); holds from done until the next accept.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_IDLE) && op_valid) begin
            cnt_d = '0;
        end else if (inv_we) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign inv_count = cnt_q;
`endif

endmodule

// File: tb/tb_tlb_inv_sweeper.sv
// -----------------------------------------------------------------------------
// tb_tlb_inv_sweeper
//
// Drives tlb_inv_sweeper against a behavioural 16-entry TLB held in the bench.
// Entries are loaded through the WB write path. Expected results come from a
// model of the INVTLB matching rules applied to a snapshot of the TLB.
// Define TLB_INV_COUNT_EN to also check inv_count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tlb_inv_sweeper;

    localparam int N = 16;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid;
    logic          op_ready;
    logic [4:0]    op_code;
    logic [9:0]    op_asid;
    logic [18:0]   op_vppn;
    logic          busy, done, op_err;
    logic [W-1:0]  r_index;
    logic          r_e;
    logic [18:0]   r_vppn;
    logic [5:0]    r_ps;
    logic [9:0]    r_asid;
    logic          r_g;
    logic          wb_we;
    logic [W-1:0]  wb_index;
    logic          we;
    logic [W-1:0]  w_index;
    logic          w_inv;
`ifdef TLB_INV_COUNT_EN
    logic [W:0]    inv_count;
`endif

    tlb_inv_sweeper #(.TLBNUM(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_asid  (op_asid),
        .op_vppn  (op_vppn),
        .busy     (busy),
        .done     (done),
        .op_err   (op_err),
        .r_index  (r_index),
        .r_e      (r_e),
        .r_vppn   (r_vppn),
        .r_ps     (r_ps),
        .r_asid   (r_asid),
        .r_g      (r_g),
        .wb_we    (wb_we),
        .wb_index (wb_index),
        .we       (we),
        .w_index  (w_index),
        .w_inv    (w_inv)
`ifdef TLB_INV_COUNT_EN
        ,
        .inv_count(inv_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural TLB: combinational read, write on the clock edge.
    logic        t_e    [N];
    logic        t_g    [N];
    logic [9:0]  t_asid [N];
    logic [18:0] t_vppn [N];
    logic [5:0]  t_ps   [N];
    // WB write data
    logic        d_e, d_g;
    logic [9:0]  d_asid;
    logic [18:0] d_vppn;
    logic [5:0]  d_ps;

    assign r_e    = t_e[r_index];
    assign r_g    = t_g[r_index];
    assign r_asid = t_asid[r_index];
    assign r_vppn = t_vppn[r_index];
    assign r_ps   = t_ps[r_index];

    always @(posedge clk) begin
        if (we) begin
            if (w_inv) begin
                t_e[w_index] <= 1'b0;
            end else begin
                t_e[w_index]    <= d_e;
                t_g[w_index]    <= d_g;
                t_asid[w_index] <= d_asid;
                t_vppn[w_index] <= d_vppn;
                t_ps[w_index]   <= d_ps;
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Snapshot taken before an op, and the model's expected E bits after it.
    logic        s_e    [N];
    logic        s_g    [N];
    logic [9:0]  s_asid [N];
    logic [18:0] s_vppn [N];
    logic [5:0]  s_ps   [N];
    logic        exp_e  [N];
    int          exp_hits;

    // INVTLB matching rules.
    function automatic logic hit(input logic [4:0] code, input logic [9:0] asid,
                                 input logic [18:0] vppn, input logic e, input logic g,
                                 input logic [9:0] ea, input logic [18:0] ev,
                                 input logic [5:0] ps);
        int   sh;
        logic am, vm;
        sh = (ps == 6'd21) ? 9 : 0;
        am = (ea == asid);
        vm = ((ev >> sh) == (vppn >> sh));
        if (!e) return 1'b0;
        case (code)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return g;
            5'd3:       return !g;
            5'd4:       return !g && am;
            5'd5:       return !g && am && vm;
            5'd6:       return (g || am) && vm;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic load(input int i, input logic e, input logic g, input logic [9:0] a,
                        input logic [18:0] v, input logic [5:0] ps);
        @(negedge clk);
        wb_we = 1'b1; wb_index = W'(i);
        d_e = e; d_g = g; d_asid = a; d_vppn = v; d_ps = ps;
        #1;
        n_chk++;
        if (we !== 1'b1 || w_index !== W'(i) || w_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_passthrough: we=%b w_index=%0d w_inv=%b, want 1/%0d/0", we, w_index, w_inv, i);
        end
        @(posedge clk); #1;
        wb_we = 1'b0;
    endtask

    task automatic snap_and_model(input logic [4:0] code, input logic [9:0] asid,
                                  input logic [18:0] vppn, input logic wr_valid, input int wr_idx);
        exp_hits = 0;
        for (int i = 0; i < N; i++) begin
            logic h;
            s_e[i] = t_e[i]; s_g[i] = t_g[i]; s_asid[i] = t_asid[i];
            s_vppn[i] = t_vppn[i]; s_ps[i] = t_ps[i];
            h = hit(code, asid, vppn, s_e[i], s_g[i], s_asid[i], s_vppn[i], s_ps[i]);
            exp_hits += int'(h);
            exp_e[i] = s_e[i] && !h && !(wr_valid && i == wr_idx);
        end
    endtask

    // Runs one legal op. Stall cycles (mask bits, cycle numbers 1..15) write an
    // E=0 entry at st_idx through the WB port. Every sweep cycle is checked
    // against the expected read position and the rule-derived invalidate.
    task automatic run_op(input logic [4:0] code, input logic [9:0] asid, input logic [18:0] vppn,
                          input logic [31:0] stall_mask, input int st_idx,
                          output int done_cyc, output int cnt_obs, output int inv_obs);
        int   exp_idx;
        logic exp_inv;
        @(negedge clk);
        op_valid = 1'b1; op_code = code; op_asid = asid; op_vppn = vppn; wb_we = 1'b0;
        #1;
        n_chk++;
        if (op_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL accept: op_ready=%b busy=%b, want 1/0", op_ready, busy);
        end
        exp_idx = 0; done_cyc = -1; cnt_obs = -1; inv_obs = 0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(negedge clk);
            // op_valid outside IDLE must be ignored
            op_valid = 1'($urandom_range(0, 1));
            op_code  = 5'($urandom);
            wb_we    = (cyc < 32) ? stall_mask[cyc] : 1'b0;
            wb_index = W'(st_idx);
            d_e = 1'b0; d_g = 1'($urandom); d_asid = 10'($urandom);
            d_vppn = 19'($urandom); d_ps = 6'd12;
            #1;
            if (exp_idx == N) begin
                n_chk++;
                if (done !== 1'b1 || op_err !== 1'b0 || busy !== 1'b1 || op_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_pulse: done=%b op_err=%b busy=%b op_ready=%b, want 1/0/1/0",
                             done, op_err, busy, op_ready);
                end
                done_cyc = cyc;
`ifdef TLB_INV_COUNT_EN
                cnt_obs = int'(inv_count);
`endif
                break;
            end
            n_chk++;
            if (busy !== 1'b1 || op_ready !== 1'b0 || done !== 1'b0 || r_index !== W'(exp_idx)) begin
                n_fail++;
                $display("FAIL sweep_state cyc %0d: busy=%b ready=%b done=%b r_index=%0d, want 1/0/0/%0d",
                         cyc, busy, op_ready, done, r_index, exp_idx);
            end
            if (wb_we) begin
                n_chk++;
                if (we !== 1'b1 || w_index !== W'(st_idx) || w_inv !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_write cyc %0d: we=%b w_index=%0d w_inv=%b, want 1/%0d/0",
                             cyc, we, w_index, w_inv, st_idx);
                end
            end else begin
                exp_inv = hit(code, asid, vppn, t_e[exp_idx], t_g[exp_idx], t_asid[exp_idx],
                              t_vppn[exp_idx], t_ps[exp_idx]);
                n_chk++;
                if (we !== exp_inv || w_inv !== exp_inv || (exp_inv && w_index !== W'(exp_idx))) begin
                    n_fail++;
                    $display("FAIL invalidate entry %0d: we=%b w_inv=%b w_index=%0d, want %b/%b/%0d",
                             exp_idx, we, w_inv, w_index, exp_inv, exp_inv, exp_idx);
                end
                inv_obs += int'(exp_inv);
                exp_idx++;
            end
        end
        op_valid = 1'b0; wb_we = 1'b0;
        if (done_cyc < 0) begin
            n_chk++; n_fail++;
            $display("FAIL sweep_timeout: no done within 200 cycles, want done");
        end
        @(posedge clk); #1;
    endtask

    task automatic check_entries(input string name);
        for (int i = 0; i < N; i++) begin
            n_chk++;
            if (t_e[i] !== exp_e[i]) begin
                n_fail++;
                $display("FAIL %s entry %0d: E=%b, want %b", name, i, t_e[i], exp_e[i]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; op_valid = 1'b0; op_code = '0; op_asid = '0; op_vppn = '0;
        wb_we = 1'b0; wb_index = '0;
        d_e = 1'b0; d_g = 1'b0; d_asid = '0; d_vppn = '0; d_ps = 6'd12;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (op_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || op_err !== 1'b0 ||
            we !== 1'b0 || w_inv !== 1'b0 || r_index !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b err=%b we=%b w_inv=%b r_index=%0d, want 1/0/0/0/0/0/0",
                     op_ready, busy, done, op_err, we, w_inv, r_index);
        end
`ifdef TLB_INV_COUNT_EN
        n_chk++;
        if (inv_count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: inv_count=%0d, want 0", inv_count);
        end
`endif
        @(negedge clk); rst = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_op2_global;
        int dc, cnt, inv;
        for (int i = 0; i < N; i++) load(i, 1'b1, 1'(i & 1), 10'(i), 19'($urandom), 6'd12);
        snap_and_model(5'd2, 10'h0, 19'h0, 1'b0, 0);
        run_op(5'd2, 10'($urandom), 19'($urandom), 32'h0, 0, dc, cnt, inv);
        n_chk++;
        if (dc !== N + 1) begin
            n_fail++;
            $display("FAIL op2_latency: done at cycle %0d, want %0d", dc, N + 1);
        end
        check_entries("op2_entries");
`ifdef TLB_INV_COUNT_EN
        n_chk++;
        if (cnt !== 8) begin
            n_fail++;
            $display("FAIL op2_count: inv_count=%0d, want 8", cnt);
        end
`endif
        $display("test_op2_global: done_cycle=%0d invalidated=%0d", dc, inv);
    endtask

    task automatic test_op5_pagesize;
        int dc, cnt, inv;
        for (int i = 0; i < N; i++) load(i, 1'b1, 1'b0, 10'h100 + 10'(i), 19'($urandom), 6'd12);
        load(5, 1'b1, 1'b0, 10'h3, 19'h12345, 6'd12);
        load(6, 1'b1, 1'b0, 10'h3, 19'h12345, 6'd21);
        // 0x12200 shares vppn[18:9] with 0x12345 but differs in the low bits
        snap_and_model(5'd5, 10'h3, 19'h12200, 1'b0, 0);
        run_op(5'd5, 10'h3, 19'h12200, 32'h0, 0, dc, cnt, inv);
        check_entries("op5_entries");
        n_chk++;
        if (t_e[5] !== 1'b1 || t_e[6] !== 1'b0) begin
            n_fail++;
            $display("FAIL op5_pagesize: E5=%b E6=%b, want 1/0", t_e[5], t_e[6]);
        end
`ifdef TLB_INV_COUNT_EN
        n_chk++;
        if (cnt !== 1) begin
            n_fail++;
            $display("FAIL op5_count: inv_count=%0d, want 1", cnt);
        end
`endif
        $display("test_op5_pagesize: done_cycle=%0d invalidated=%0d", dc, inv);
    endtask

    task automatic test_back_to_back_stall;
        int dc, cnt, inv;
        for (int i = 0; i < N; i++) load(i, 1'b1, 1'($urandom), 10'($urandom), 19'($urandom), 6'd12);
        snap_and_model(5'd0, 10'h0, 19'h0, 1'b1, 2);
        run_op(5'd0, 10'h0, 19'h0, (32'h1 << 4) | (32'h1 << 9), 2, dc, cnt, inv);
        n_chk++;
        if (dc !== N + 3) begin
            n_fail++;
            $display("FAIL stall_latency: done at cycle %0d, want %0d", dc, N + 3);
        end
        check_entries("stall_entries");
        $display("test_back_to_back_stall: done_cycle=%0d invalidated=%0d", dc, inv);
    endtask

    task automatic test_illegal_op;
        logic [4:0] c;
        c = 5'($urandom_range(7, 31));
        @(negedge clk);
        op_valid = 1'b1; op_code = c; #1;
        n_chk++;
        if (op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_accept: op_ready=%b, want 1", op_ready);
        end
        @(negedge clk);
        op_valid = 1'b0;
        // WB write during DONE passes straight through
        wb_we = 1'b1; wb_index = W'(7); d_e = 1'b1; d_g = 1'b0; d_asid = 10'h7; d_vppn = 19'h7; d_ps = 6'd12;
        #1;
        n_chk++;
        if (done !== 1'b1 || op_err !== 1'b1 || busy !== 1'b1 || op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_done: done=%b op_err=%b busy=%b ready=%b, want 1/1/1/0", done, op_err, busy, op_ready);
        end
        n_chk++;
        if (we !== 1'b1 || w_index !== W'(7) || w_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL done_passthrough: we=%b w_index=%0d w_inv=%b, want 1/7/0", we, w_index, w_inv);
        end
`ifdef TLB_INV_COUNT_EN
        n_chk++;
        if (inv_count !== '0) begin
            n_fail++;
            $display("FAIL illegal_count: inv_count=%0d, want 0", inv_count);
        end
`endif
        @(negedge clk);
        wb_we = 1'b0; #1;
        n_chk++;
        if (done !== 1'b0 || op_err !== 1'b0 || op_ready !== 1'b1 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_return: done=%b op_err=%b ready=%b we=%b, want 0/0/1/0", done, op_err, op_ready, we);
        end
        $display("test_illegal_op: code=%0d", c);
    endtask

    task automatic test_reset_mid_sweep;
        int dc, cnt, inv;
        for (int i = 0; i < N; i++) load(i, 1'b1, 1'($urandom), 10'($urandom), 19'($urandom), 6'd12);
        @(negedge clk);
        op_valid = 1'b1; op_code = 5'd1; #1;
        @(negedge clk);
        op_valid = 1'b0;
        // cycle 9 reads entry 8; reset before that edge
        repeat (8) @(negedge clk);
        #1;
        n_chk++;
        if (r_index !== W'(8) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_abort: r_index=%0d busy=%b, want 8/1", r_index, busy);
        end
        rst = 1'b0; #1;
        n_chk++;
        if (op_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || op_err !== 1'b0 ||
            we !== 1'b0 || w_inv !== 1'b0 || r_index !== '0) begin
            n_fail++;
            $display("FAIL abort_state: ready=%b busy=%b done=%b err=%b we=%b w_inv=%b r_index=%0d, want 1/0/0/0/0/0/0",
                     op_ready, busy, done, op_err, we, w_inv, r_index);
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < N; i++) exp_e[i] = (i >= 8);
        check_entries("abort_entries");
        snap_and_model(5'd0, 10'h0, 19'h0, 1'b0, 0);
        run_op(5'd0, 10'h0, 19'h0, 32'h0, 0, dc, cnt, inv);
        n_chk++;
        if (dc !== N + 1) begin
            n_fail++;
            $display("FAIL post_abort_latency: done at cycle %0d, want %0d", dc, N + 1);
        end
        check_entries("post_abort_entries");
        $display("test_reset_mid_sweep: post-abort done_cycle=%0d invalidated=%0d", dc, inv);
    endtask

    task automatic test_op6_global_or_asid;
        int dc, cnt, inv;
        for (int i = 0; i < N; i++)
            load(i, 1'b1, 1'b0, 10'($urandom_range(0, 10'h3FE)), (i % 2 == 0) ? 19'h002AB : 19'($urandom_range(19'h10000, 19'h7FFFF)), 6'd12);
        load(10, 1'b1, 1'b1, 10'h055, 19'h002AB, 6'd12);
        snap_and_model(5'd6, 10'h3FF, 19'h002AB, 1'b0, 0);
        run_op(5'd6, 10'h3FF, 19'h002AB, 32'h0, 0, dc, cnt, inv);
        check_entries("op6_entries");
        n_chk++;
        if (t_e[10] !== 1'b0 || t_e[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL op6_global: E10=%b E0=%b, want 0/1", t_e[10], t_e[0]);
        end
        $display("test_op6_global_or_asid: done_cycle=%0d invalidated=%0d", dc, inv);
    endtask

    task automatic test_random;
        int dc, cnt, inv, nst, st_idx;
        logic [31:0] mask;
        logic [18:0] pool [3];
        logic [4:0]  code;
        logic [9:0]  asid;
        logic [18:0] vppn;
        for (int it = 0; it < 10; it++) begin
            for (int p = 0; p < 3; p++) pool[p] = 19'($urandom);
            for (int i = 0; i < N; i++)
                load(i, 1'($urandom_range(0, 3) != 0), 1'($urandom), 10'($urandom_range(0, 3)),
                     pool[$urandom_range(0, 2)] ^ 19'($urandom_range(0, 511)),
                     ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12);
            code = 5'($urandom_range(0, 6));
            asid = 10'($urandom_range(0, 3));
            vppn = ($urandom_range(0, 1) != 0) ? t_vppn[$urandom_range(0, N - 1)] : pool[$urandom_range(0, 2)];
            mask = '0;
            if (it % 2 == 1) begin
                mask[$urandom_range(1, 15)] = 1'b1;
                mask[$urandom_range(1, 15)] = 1'b1;
            end
            st_idx = $urandom_range(0, N - 1);
            nst = $countones(mask);
            snap_and_model(code, asid, vppn, nst != 0, st_idx);
            run_op(code, asid, vppn, mask, st_idx, dc, cnt, inv);
            n_chk++;
            if (dc !== N + 1 + nst) begin
                n_fail++;
                $display("FAIL random_latency it %0d: done at cycle %0d, want %0d", it, dc, N + 1 + nst);
            end
            check_entries("random_entries");
`ifdef TLB_INV_COUNT_EN
            if (nst == 0) begin
                n_chk++;
                if (cnt !== exp_hits) begin
                    n_fail++;
                    $display("FAIL random_count it %0d: inv_count=%0d, want %0d", it, cnt, exp_hits);
                end
            end
`endif
            $display("test_random it %0d: op=%0d asid=%0h vppn=%0h stalls=%0d done_cycle=%0d invalidated=%0d",
                     it, code, asid, vppn, nst, dc, inv);
        end
    endtask

    initial begin
        test_reset();
        test_op2_global();
        test_op5_pagesize();
        test_back_to_back_stall();
        test_illegal_op();
        test_reset_mid_sweep();
        test_op6_global_or_asid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
